// File: rtl/csr_pkg.sv
// csr_pkg: shared definitions for the machine-mode CSR / interrupt block.
//   - CSR address constants (including the optional 64-bit counters)
//   - csr_op_e    : CSR read-modify-write operation encoding
//   - irq_state_e : trap sequencer states (RUN, SLEEP)
//   - field bit positions inside MSTATUS / MIE / MIP
//   - csr_apply_op: old/wdata combine for CSRRW/CSRRS/CSRRC
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef enum logic [1:0] {
    CSR_RW = 2'b00,
    CSR_RS = 2'b01,
    CSR_RC = 2'b10
  } csr_op_e;

  typedef enum logic {
    RUN   = 1'b0,
    SLEEP = 1'b1
  } irq_state_e;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MSTATUS_MPP_LO   = 11;
  localparam int unsigned MSTATUS_MPP_HI   = 12;
  localparam int unsigned MIE_MTIE_BIT     = 7;
  localparam int unsigned MIE_MEIE_BIT     = 11;

  // Unused encoding 2'b11 leaves the register unchanged.
  function automatic logic [31:0] csr_apply_op(input logic [1:0] op,
                                               input logic [31:0] old_val,
                                               input logic [31:0] wdata);
    logic [31:0] res;
    case (csr_op_e'(op))
      CSR_RW:  res = wdata;
      CSR_RS:  res = old_val | wdata;
      CSR_RC:  res = old_val & ~wdata;
      default: res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit free-running / event counter with 32-bit half writes.
// Ports:
//   clk, rst       clock, asynchronous active-low reset (count -> 0)
//   inc_i          increment by one this cycle
//   we_lo_i        load wdata_i into bits [31:0]  (wins over inc_i)
//   we_hi_i        load wdata_i into bits [63:32] (wins over inc_i)
//   wdata_i        write data
//   value_o        current count
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  input  logic        we_lo_i,
  input  logic        we_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] value_o
);

  logic [63:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (we_lo_i) begin
      cnt_q <= {cnt_q[63:32], wdata_i};
    end else if (we_hi_i) begin
      cnt_q <= {wdata_i, cnt_q[31:0]};
    end else if (inc_i) begin
      cnt_q <= cnt_q + 64'd1;
    end
  end

  assign value_o = cnt_q;

endmodule

// File: rtl/csr_irq_ctrl.sv
// csr_irq_ctrl: machine-mode CSR file plus trap / MRET / WFI sequencer.
// Optional feature macro: CSR_COUNTER_EN (adds MCYCLE/MINSTRET 64-bit counters).
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   stall_in            pipeline frozen; nothing commits
//   ex_valid, ex_pc     EX instruction valid flag and its PC
//   csr_we, csr_op      CSR instruction in EX and its RW/RS/RC operation
//   csr_addr, csr_wdata CSR address and operand
//   is_mret, is_wfi     EX decode flags
//   ext_irq, timer_irq  level interrupt lines
//   csr_rdata           combinational pre-write read of csr_addr
//   redirect_valid/pc   registered one-cycle flush + fetch target
//   wfi_stall           registered pipeline hold while sleeping
module csr_irq_ctrl
  import csr_pkg::*;
#(
  parameter logic [31:0] CSR_TVEC = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        csr_we,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        is_mret,
  input  logic        is_wfi,
  input  logic        ext_irq,
  input  logic        timer_irq,
  output logic [31:0] csr_rdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        wfi_stall
);

  irq_state_e  state_q;
  logic        mie_q, mpie_q;
  logic [1:0]  mpp_q;
  logic        mtie_q, meie_q;
  logic [31:0] mepc_q, wfi_pc_q;
  logic        redirect_valid_q, wfi_stall_q;
  logic [31:0] redirect_pc_q;

  logic [31:0] mstatus_rd, mie_rd, mip_rd, wr_val, trap_epc;
  logic        pend, commit, in_run, take, wake, trap_fire;
  logic        mret_fire, csr_commit, wfi_fire;
  logic        unused_bits;

  assign mstatus_rd = {19'd0, mpp_q, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};
  assign mie_rd     = {20'd0, meie_q, 3'd0, mtie_q, 7'd0};
  assign mip_rd     = {20'd0, ext_irq, 3'd0, timer_irq, 7'd0};

`ifdef CSR_COUNTER_EN
  logic [63:0] mcycle, minstret;
`endif

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS:   csr_rdata = mstatus_rd;
      CSR_MIE:       csr_rdata = mie_rd;
      CSR_MTVEC:     csr_rdata = CSR_TVEC;
      CSR_MEPC:      csr_rdata = mepc_q;
      CSR_MIP:       csr_rdata = mip_rd;
`ifdef CSR_COUNTER_EN
      CSR_MCYCLE:    csr_rdata = mcycle[31:0];
      CSR_MCYCLEH:   csr_rdata = mcycle[63:32];
      CSR_MINSTRET:  csr_rdata = minstret[31:0];
      CSR_MINSTRETH: csr_rdata = minstret[63:32];
`endif
      default:       csr_rdata = '0;
    endcase
  end

  // Read-modify-write uses the pre-write read value of the addressed CSR.
  assign wr_val = csr_apply_op(csr_op, csr_rdata, csr_wdata);

  assign pend   = (meie_q & ext_irq) | (mtie_q & timer_irq);
  assign commit = ex_valid & ~stall_in;
  assign in_run = (state_q == RUN);

  // The EX slot right after a redirect is a flushed bubble, so it cannot trap.
  assign take       = in_run & mie_q & pend & commit & ~redirect_valid_q;
  assign wake       = (state_q == SLEEP) & pend & ~stall_in;
  assign trap_fire  = take | (wake & mie_q);
  assign trap_epc   = in_run ? ex_pc : wfi_pc_q;

  assign mret_fire  = in_run & commit & ~take & is_mret;
  assign csr_commit = in_run & commit & ~take & ~is_mret & csr_we;
  assign wfi_fire   = in_run & commit & ~take & ~is_mret & ~csr_we & is_wfi;

  assign unused_bits = ^{wr_val[1:0], trap_epc[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= RUN;
      mie_q            <= 1'b0;
      mpie_q           <= 1'b0;
      mpp_q            <= 2'b00;
      mtie_q           <= 1'b0;
      meie_q           <= 1'b0;
      mepc_q           <= '0;
      wfi_pc_q         <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      wfi_stall_q      <= 1'b0;
    end else begin
      redirect_valid_q <= 1'b0;

      if (trap_fire) begin
        mepc_q           <= {trap_epc[31:2], 2'b00};
        mpie_q           <= mie_q;
        mie_q            <= 1'b0;
        mpp_q            <= 2'b11;
        redirect_valid_q <= 1'b1;
        redirect_pc_q    <= CSR_TVEC;
      end else if (mret_fire) begin
        mie_q            <= mpie_q;
        mpie_q           <= 1'b1;
        mpp_q            <= 2'b11;
        redirect_valid_q <= 1'b1;
        redirect_pc_q    <= mepc_q;
      end else if (csr_commit) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            mie_q  <= wr_val[MSTATUS_MIE_BIT];
            mpie_q <= wr_val[MSTATUS_MPIE_BIT];
            mpp_q  <= wr_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
          end
          CSR_MIE: begin
            mtie_q <= wr_val[MIE_MTIE_BIT];
            meie_q <= wr_val[MIE_MEIE_BIT];
          end
          CSR_MEPC: mepc_q <= {wr_val[31:2], 2'b00};
          default: ;
        endcase
      end

      if (wfi_fire) begin
        state_q     <= SLEEP;
        wfi_stall_q <= 1'b1;
        wfi_pc_q    <= ex_pc + 32'd4;
      end else if (wake) begin
        state_q     <= RUN;
        wfi_stall_q <= 1'b0;
      end
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign wfi_stall      = wfi_stall_q;

`ifdef CSR_COUNTER_EN
  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (1'b1),
    .we_lo_i (csr_commit & (csr_addr == CSR_MCYCLE)),
    .we_hi_i (csr_commit & (csr_addr == CSR_MCYCLEH)),
    .wdata_i (wr_val),
    .value_o (mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (in_run & commit & ~take),
    .we_lo_i (csr_commit & (csr_addr == CSR_MINSTRET)),
    .we_hi_i (csr_commit & (csr_addr == CSR_MINSTRETH)),
    .wdata_i (wr_val),
    .value_o (minstret)
  );
`endif

endmodule
